// File: rtl/mixer_sequencer_pkg.sv
// Shared types and defaults for the mixer load/execute sequencer.
package mixer_sequencer_pkg;

  localparam int SAMPLE_W_DEFAULT = 8;
  localparam int MIX_W_DEFAULT    = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD1   = 3'd1,
    ST_LOAD2   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_PRESENT = 3'd5
  } state_t;

  // A frame is in flight in every state except IDLE; ticks seen then are overruns.
  function automatic logic frame_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mixer_sequencer_if.sv
// Oscillator, mixer and DAC-side signals of the sequencer; master is the sequencer itself.
interface mixer_sequencer_if
  import mixer_sequencer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int MIX_W    = MIX_W_DEFAULT
) ();

  logic                i_tick;
  logic [SAMPLE_W-1:0] i_osc1_sample;
  logic                i_osc1_valid;
  logic                o_osc1_ready;
  logic [SAMPLE_W-1:0] i_osc2_sample;
  logic                i_osc2_valid;
  logic                o_osc2_ready;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_sample_1_load;
  logic                o_sample_2_load;
  logic                o_execute;
  logic [MIX_W-1:0]    i_mix;
  logic [MIX_W-1:0]    o_dac_data;
  logic                o_dac_valid;
  logic                i_dac_ready;
  logic                o_overrun;

  modport master (
    input  i_tick,
    input  i_osc1_sample, i_osc1_valid, output o_osc1_ready,
    input  i_osc2_sample, i_osc2_valid, output o_osc2_ready,
    output o_sample, o_sample_1_load, o_sample_2_load, o_execute,
    input  i_mix,
    output o_dac_data, o_dac_valid,
    input  i_dac_ready,
    output o_overrun
  );

  modport slave (
    output i_tick,
    output i_osc1_sample, i_osc1_valid, input o_osc1_ready,
    output i_osc2_sample, i_osc2_valid, input o_osc2_ready,
    input  o_sample, o_sample_1_load, o_sample_2_load, o_execute,
    output i_mix,
    input  o_dac_data, o_dac_valid,
    output i_dac_ready,
    input  o_overrun
  );

endinterface

// File: rtl/mixer_sequencer_holding_buf.sv
// One-deep valid/ready holding buffer for one mixer slot, plus the value last loaded into it.
module mixer_sequencer_holding_buf #(
  parameter int W         = 8,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         consume,
  output logic [W-1:0] slot_value,
  output logic [W-1:0] last_value
);

  logic         full_q;
  logic [W-1:0] data_q;
  logic [W-1:0] last_q;
  logic         accept;

  // Ready while the slot is being loaded, so a waiting sample refills the same cycle.
  assign wr_ready   = !full_q || consume;
  assign accept     = wr_valid && wr_ready;
  assign slot_value = full_q ? data_q : (HOLD_LAST ? last_q : '0);
  assign last_value = last_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= '0;
    end else begin
      if (accept) begin
        full_q <= 1'b1;
        data_q <= wr_data;
      end else if (consume) begin
        full_q <= 1'b0;
      end
      if (consume) begin
        last_q <= slot_value;
      end
    end
  end

endmodule

// File: rtl/mixer_sequencer.sv
// Mixer initiator: buffers one sample per oscillator and, per sample tick, loads slot 1,
// loads slot 2, executes, captures the mix and hands it to the DAC stage.
//
//   state   | meaning
//   IDLE    | waiting for a sample-rate tick
//   LOAD1   | slot-1 value on bus, slot-1 load strobe
//   LOAD2   | slot-2 value on bus, slot-2 load strobe
//   EXEC    | execute strobe, bus held at slot-2 value
//   CAPTURE | mixer result valid, registered into DAC data
//   PRESENT | DAC data valid, waiting for DAC ready
module mixer_sequencer
  import mixer_sequencer_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int MIX_W     = MIX_W_DEFAULT,
  parameter bit HOLD_LAST = 1'b1
) (
  input logic              i_clock,
  input logic              i_reset,
  mixer_sequencer_if.master bus
);

  state_t              state_q;
  state_t              state_nxt;
  logic [SAMPLE_W-1:0] slot1_value;
  logic [SAMPLE_W-1:0] slot1_last;
  logic [SAMPLE_W-1:0] slot2_value;
  logic [SAMPLE_W-1:0] slot2_last;
  logic [SAMPLE_W-1:0] sample_mux;
  logic                load1_q;
  logic                load2_q;
  logic                exec_q;
  logic                dac_valid_q;
  logic [MIX_W-1:0]    dac_data_q;
  logic                overrun_q;

  mixer_sequencer_holding_buf #(
    .W         (SAMPLE_W),
    .HOLD_LAST (HOLD_LAST)
  ) u_slot1_buf (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .wr_data    (bus.i_osc1_sample),
    .wr_valid   (bus.i_osc1_valid),
    .wr_ready   (bus.o_osc1_ready),
    .consume    (state_q == ST_LOAD1),
    .slot_value (slot1_value),
    .last_value (slot1_last)
  );

  mixer_sequencer_holding_buf #(
    .W         (SAMPLE_W),
    .HOLD_LAST (HOLD_LAST)
  ) u_slot2_buf (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .wr_data    (bus.i_osc2_sample),
    .wr_valid   (bus.i_osc2_valid),
    .wr_ready   (bus.o_osc2_ready),
    .consume    (state_q == ST_LOAD2),
    .slot_value (slot2_value),
    .last_value (slot2_last)
  );

  // Strobes are flopped from the next state so they align with the state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      load1_q     <= 1'b0;
      load2_q     <= 1'b0;
      exec_q      <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      load1_q     <= (state_nxt == ST_LOAD1);
      load2_q     <= (state_nxt == ST_LOAD2);
      exec_q      <= (state_nxt == ST_EXEC);
      dac_valid_q <= (state_nxt == ST_PRESENT);
      overrun_q   <= bus.i_tick && frame_busy(state_q);
      if (state_q == ST_CAPTURE) begin
        dac_data_q <= bus.i_mix;
      end
    end
  end

  // slot2_last already holds the value loaded in LOAD2 when EXEC is reached.
  always_comb begin
    state_nxt  = state_q;
    sample_mux = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_tick) state_nxt = ST_LOAD1;
      end
      ST_LOAD1: begin
        state_nxt  = ST_LOAD2;
        sample_mux = slot1_value;
      end
      ST_LOAD2: begin
        state_nxt  = ST_EXEC;
        sample_mux = slot2_value;
      end
      ST_EXEC: begin
        state_nxt  = ST_CAPTURE;
        sample_mux = slot2_last;
      end
      ST_CAPTURE: begin
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.i_dac_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.o_sample        = sample_mux;
  assign bus.o_sample_1_load = load1_q;
  assign bus.o_sample_2_load = load2_q;
  assign bus.o_execute       = exec_q;
  assign bus.o_dac_data      = dac_data_q;
  assign bus.o_dac_valid     = dac_valid_q;
  assign bus.o_overrun       = overrun_q;

  logic unused_last1;
  assign unused_last1 = ^slot1_last;

endmodule

// File: tb/tb_mixer_sequencer.sv
// Directed vector table plus hand sequences and a random soak for mixer_sequencer,
// with HOLD_LAST=1 (dut) and HOLD_LAST=0 (dut_z) driven by identical stimulus.
module tb_mixer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        v1, v2, rdy;
  logic [7:0]  s1, s2;
  logic [11:0] mix;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mixer_sequencer_if #(.SAMPLE_W(8), .MIX_W(12)) bus_h ();
  mixer_sequencer_if #(.SAMPLE_W(8), .MIX_W(12)) bus_z ();

  assign bus_h.i_tick = tick;        assign bus_z.i_tick = tick;
  assign bus_h.i_osc1_valid = v1;    assign bus_z.i_osc1_valid = v1;
  assign bus_h.i_osc1_sample = s1;   assign bus_z.i_osc1_sample = s1;
  assign bus_h.i_osc2_valid = v2;    assign bus_z.i_osc2_valid = v2;
  assign bus_h.i_osc2_sample = s2;   assign bus_z.i_osc2_sample = s2;
  assign bus_h.i_mix = mix;          assign bus_z.i_mix = mix;
  assign bus_h.i_dac_ready = rdy;    assign bus_z.i_dac_ready = rdy;

  mixer_sequencer #(.SAMPLE_W(8), .MIX_W(12), .HOLD_LAST(1'b1)) dut (
    .i_clock (clk), .i_reset (rst), .bus (bus_h));
  mixer_sequencer #(.SAMPLE_W(8), .MIX_W(12), .HOLD_LAST(1'b0)) dut_z (
    .i_clock (clk), .i_reset (rst), .bus (bus_z));

  typedef struct {
    logic tick, v1; logic [7:0] s1; logic v2; logic [7:0] s2; logic [11:0] mix; logic rdy;
    logic [7:0] e_smp, e_smp_z; logic e_l1, e_l2, e_ex, e_dv; logic [11:0] e_data;
    logic e_r1, e_r2, e_ovr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(int tk, int a1, int d1, int a2, int d2, int mx, int rd,
                              int es, int esz, int l1, int l2, int ex, int dv, int data,
                              int r1, int r2, int ov);
    vec_t v;
    v.tick = tk[0]; v.v1 = a1[0]; v.s1 = d1[7:0]; v.v2 = a2[0]; v.s2 = d2[7:0];
    v.mix = mx[11:0]; v.rdy = rd[0]; v.e_smp = es[7:0]; v.e_smp_z = esz[7:0];
    v.e_l1 = l1[0]; v.e_l2 = l2[0]; v.e_ex = ex[0]; v.e_dv = dv[0]; v.e_data = data[11:0];
    v.e_r1 = r1[0]; v.e_r2 = r2[0]; v.e_ovr = ov[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic pl1, ppl1, pl2;

    // tick v1 s1 v2 s2 mix rdy | smp smp_z l1 l2 ex dv data r1 r2 ovr
    vecs[0]  = mk(0,1,'h40,1,'h80,'h000,0, 'h00,'h00,0,0,0,0,'h000,1,1,0);
    vecs[1]  = mk(1,0,'h00,0,'h00,'h000,0, 'h00,'h00,0,0,0,0,'h000,0,0,0);
    vecs[2]  = mk(0,0,'h00,0,'h00,'h000,0, 'h40,'h40,1,0,0,0,'h000,1,0,0);
    vecs[3]  = mk(0,0,'h00,0,'h00,'h000,0, 'h80,'h80,0,1,0,0,'h000,1,1,0);
    vecs[4]  = mk(0,0,'h00,0,'h00,'h000,0, 'h80,'h80,0,0,1,0,'h000,1,1,0);
    vecs[5]  = mk(0,0,'h00,0,'h00,'h0C0,0, 'h00,'h00,0,0,0,0,'h000,1,1,0);
    vecs[6]  = mk(0,0,'h00,0,'h00,'h0C0,1, 'h00,'h00,0,0,0,1,'h0C0,1,1,0);
    vecs[7]  = mk(0,0,'h00,0,'h00,'h0C0,0, 'h00,'h00,0,0,0,0,'h0C0,1,1,0);
    vecs[8]  = mk(1,0,'h00,0,'h00,'h0C0,0, 'h00,'h00,0,0,0,0,'h0C0,1,1,0);
    vecs[9]  = mk(0,0,'h00,0,'h00,'h0C0,0, 'h40,'h00,1,0,0,0,'h0C0,1,1,0);
    vecs[10] = mk(0,0,'h00,0,'h00,'h0C0,0, 'h80,'h00,0,1,0,0,'h0C0,1,1,0);
    vecs[11] = mk(0,0,'h00,0,'h00,'h0C0,0, 'h80,'h00,0,0,1,0,'h0C0,1,1,0);
    vecs[12] = mk(0,0,'h00,0,'h00,'h123,0, 'h00,'h00,0,0,0,0,'h0C0,1,1,0);
    vecs[13] = mk(1,0,'h00,0,'h00,'h123,1, 'h00,'h00,0,0,0,1,'h123,1,1,0);
    vecs[14] = mk(0,0,'h00,0,'h00,'h123,0, 'h00,'h00,0,0,0,0,'h123,1,1,1);
    vecs[15] = mk(0,0,'h00,0,'h00,'h123,0, 'h00,'h00,0,0,0,0,'h123,1,1,0);

    rst = 1'b1; tick = 0; v1 = 0; v2 = 0; s1 = 0; s2 = 0; mix = 0; rdy = 0;
    #12;
    chk("reset ready1", bus_h.o_osc1_ready, 1);
    chk("reset ready2", bus_h.o_osc2_ready, 1);
    chk("reset strobes", {bus_h.o_sample_1_load, bus_h.o_sample_2_load, bus_h.o_execute}, 0);
    chk("reset dac", {bus_h.o_dac_valid, bus_h.o_dac_data, bus_h.o_overrun}, 0);
    chk("reset sample", bus_h.o_sample, 0);
    #10 rst = 1'b0;
    step();

    // Basic frame, held-sample frame, tick during PRESENT accept cycle.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d sample", i),   bus_h.o_sample, vecs[i].e_smp);
      chk($sformatf("v%0d sample_z", i), bus_z.o_sample, vecs[i].e_smp_z);
      chk($sformatf("v%0d load1", i),    bus_h.o_sample_1_load, vecs[i].e_l1);
      chk($sformatf("v%0d load2", i),    bus_h.o_sample_2_load, vecs[i].e_l2);
      chk($sformatf("v%0d execute", i),  bus_h.o_execute, vecs[i].e_ex);
      chk($sformatf("v%0d strobes_z", i),
          {bus_z.o_sample_1_load, bus_z.o_sample_2_load, bus_z.o_execute},
          {vecs[i].e_l1, vecs[i].e_l2, vecs[i].e_ex});
      chk($sformatf("v%0d dac_valid", i), bus_h.o_dac_valid, vecs[i].e_dv);
      chk($sformatf("v%0d dac_data", i),  bus_h.o_dac_data, vecs[i].e_data);
      chk($sformatf("v%0d ready1", i),    bus_h.o_osc1_ready, vecs[i].e_r1);
      chk($sformatf("v%0d ready2", i),    bus_h.o_osc2_ready, vecs[i].e_r2);
      chk($sformatf("v%0d overrun", i),   bus_h.o_overrun, vecs[i].e_ovr);
      tick = vecs[i].tick; v1 = vecs[i].v1; s1 = vecs[i].s1; v2 = vecs[i].v2;
      s2 = vecs[i].s2; mix = vecs[i].mix; rdy = vecs[i].rdy;
      step();
    end

    // DAC stall of 10 cycles with a tick in stall cycle 5.
    tick = 1; step(); tick = 0;
    chk("stall load1", bus_h.o_sample_1_load, 1);
    chk("stall load1 sample", bus_h.o_sample, 8'h40);
    step(); step();
    chk("stall execute", bus_h.o_execute, 1);
    step();
    mix = 12'h3A5;
    step();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("stall%0d dac_valid", k), bus_h.o_dac_valid, 1);
      chk($sformatf("stall%0d dac_data", k), bus_h.o_dac_data, 12'h3A5);
      chk($sformatf("stall%0d strobes", k),
          {bus_h.o_sample_1_load, bus_h.o_sample_2_load, bus_h.o_execute}, 0);
      chk($sformatf("stall%0d overrun", k), bus_h.o_overrun, 32'(k == 6));
      tick = (k == 5);
      mix = 12'h0FF;
      step();
    end
    chk("stall end dac_valid", bus_h.o_dac_valid, 1);
    chk("stall end no load", bus_h.o_sample_1_load, 0);
    rdy = 1; step(); rdy = 0;
    chk("stall release dac_valid", bus_h.o_dac_valid, 0);

    // Refill of slot 1 in the same cycle it is loaded.
    v1 = 1; s1 = 8'h33; v2 = 1; s2 = 8'h44; step();
    chk("refill ready1 full", bus_h.o_osc1_ready, 0);
    s1 = 8'h55; v2 = 0; tick = 1; step(); tick = 0;
    chk("refill load1 sample", bus_h.o_sample, 8'h33);
    chk("refill ready1 on load", bus_h.o_osc1_ready, 1);
    step(); v1 = 0;
    chk("refill ready1 after", bus_h.o_osc1_ready, 0);
    chk("refill load2 sample", bus_h.o_sample, 8'h44);
    step(); step(); step();
    chk("refill dac_valid", bus_h.o_dac_valid, 1);
    rdy = 1; step(); rdy = 0;
    tick = 1; step(); tick = 0;
    chk("refill next load1", bus_h.o_sample, 8'h55);
    chk("refill next load1 z", bus_z.o_sample, 8'h55);
    step();
    chk("refill next load2", bus_h.o_sample, 8'h44);
    chk("refill next load2 z", bus_z.o_sample, 8'h00);
    step(); step(); step();
    rdy = 1; step(); rdy = 0;

    // Reset asserted during LOAD2.
    v1 = 1; s1 = 8'h66; v2 = 1; s2 = 8'h77; step();
    v1 = 0; v2 = 0; tick = 1; step(); tick = 0;
    chk("rst load1 sample", bus_h.o_sample, 8'h66);
    step();
    chk("rst load2 before", bus_h.o_sample_2_load, 1);
    chk("rst load2 sample", bus_h.o_sample, 8'h77);
    #2 rst = 1'b1;
    #1;
    chk("rst strobes", {bus_h.o_sample_1_load, bus_h.o_sample_2_load, bus_h.o_execute}, 0);
    chk("rst strobes z", {bus_z.o_sample_1_load, bus_z.o_sample_2_load, bus_z.o_execute}, 0);
    chk("rst sample", bus_h.o_sample, 0);
    chk("rst ready1", bus_h.o_osc1_ready, 1);
    chk("rst ready2", bus_h.o_osc2_ready, 1);
    #3 rst = 1'b0;
    step();
    chk("rst no execute a", bus_h.o_execute, 0);
    step();
    chk("rst no execute b", bus_h.o_execute, 0);
    tick = 1; step(); tick = 0;
    chk("rst frame load1", bus_h.o_sample_1_load, 1);
    chk("rst frame sample1", bus_h.o_sample, 8'h00);
    step();
    chk("rst frame load2", bus_h.o_sample_2_load, 1);
    chk("rst frame sample2", bus_h.o_sample, 8'h00);
    step();
    chk("rst frame execute", bus_h.o_execute, 1);
    step(); step();
    chk("rst frame dac_valid", bus_h.o_dac_valid, 1);
    rdy = 1; step(); rdy = 0;

    // Random soak: strobes one-hot and always in load1, load2, execute order.
    pl1 = 0; ppl1 = 0; pl2 = 0;
    for (int c = 0; c < 400; c++) begin
      n = int'(bus_h.o_sample_1_load) + int'(bus_h.o_sample_2_load) + int'(bus_h.o_execute);
      chk("soak one strobe", 32'(n <= 1), 1);
      chk("soak z strobes match",
          {bus_z.o_sample_1_load, bus_z.o_sample_2_load, bus_z.o_execute},
          {bus_h.o_sample_1_load, bus_h.o_sample_2_load, bus_h.o_execute});
      if (bus_h.o_execute)       chk("soak exec order", {ppl1, pl2}, 2'b11);
      if (bus_h.o_sample_2_load) chk("soak load2 order", pl1, 1);
      ppl1 = pl1; pl1 = bus_h.o_sample_1_load; pl2 = bus_h.o_sample_2_load;
      tick = ($urandom_range(0, 5) == 0);
      v1 = 1'($urandom_range(0, 1)); s1 = 8'($urandom_range(0, 255));
      v2 = 1'($urandom_range(0, 1)); s2 = 8'($urandom_range(0, 255));
      mix = 12'($urandom_range(0, 4095));
      rdy = 1'($urandom_range(0, 1));
      step();
    end
    tick = 0; v1 = 0; v2 = 0; rdy = 1;
    repeat (8) step();
    chk("soak drained dac_valid", bus_h.o_dac_valid, 0);
    chk("soak drained strobes",
        {bus_h.o_sample_1_load, bus_h.o_sample_2_load, bus_h.o_execute}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
